// File: rtl/sh7034_ibus_pkg.sv
// Shared types and lane helpers for the SH7034 IBUS initiator.
package sh7034_ibus_pkg;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BA_W   = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_WORD = 2'd1,
    SZ_LONG = 2'd2,
    SZ_RSVD = 2'd3
  } sz_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  // Big-endian strobes: BA[3] is the lowest byte address (bits 31:24).
  function automatic logic [BA_W-1:0] ba_gen(input logic [1:0] a, input sz_e sz);
    case (sz)
      SZ_BYTE: return 4'b1000 >> a;
      SZ_WORD: return a[1] ? 4'b0011 : 4'b1100;
      SZ_LONG: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] wd_rep(input sz_e sz, input logic [DATA_W-1:0] wd);
    case (sz)
      SZ_BYTE: return {4{wd[7:0]}};
      SZ_WORD: return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] rd_ext(input logic [1:0] a, input sz_e sz,
                                               input logic sign, input logic [DATA_W-1:0] di);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = di[31:24];
      2'd1:    b = di[23:16];
      2'd2:    b = di[15:8];
      default: b = di[7:0];
    endcase
    h = a[1] ? di[15:0] : di[31:16];
    case (sz)
      SZ_BYTE: return {{24{sign & b[7]}}, b};
      SZ_WORD: return {{16{sign & h[15]}}, h};
      default: return di;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] a, input sz_e sz);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_WORD: return a[0];
      SZ_LONG: return a != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sh7034_ibus_lane.sv
// Byte-lane steering: strobe generation, write replication, read alignment/extension.
module sh7034_ibus_lane
  import sh7034_ibus_pkg::*;
(
  input  logic [1:0]        a,
  input  sz_e               sz,
  input  logic              sign,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] di,
  output logic [BA_W-1:0]   ba_c,
  output logic [DATA_W-1:0] wdat_c,
  output logic [DATA_W-1:0] rdat_c
);

  assign ba_c   = ba_gen(a, sz);
  assign wdat_c = wd_rep(sz, wd);
  assign rdat_c = rd_ext(a, sz, sign, di);

endmodule

// File: rtl/sh7034_ibus_master.sv
// SH7034 IBUS initiator: turns single CPU load/store requests into IBUS transactions.
module sh7034_ibus_master
  import sh7034_ibus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE_R,
  input  logic              CE_F,
  input  logic              REQ_VALID,
  input  logic [ADDR_W-1:0] REQ_A,
  input  logic              REQ_WE,
  input  logic [1:0]        REQ_SZ,
  input  logic              REQ_SIGN,
  input  logic [DATA_W-1:0] REQ_WD,
  output logic              REQ_ACK,
  output logic [DATA_W-1:0] REQ_RD,
  output logic              REQ_ERR,
  output logic              REQ_BUSY,
  output logic [ADDR_W-1:0] IBUS_A,
  output logic [DATA_W-1:0] IBUS_DO,
  input  logic [DATA_W-1:0] IBUS_DI,
  output logic [BA_W-1:0]   IBUS_BA,
  output logic              IBUS_WE,
  output logic              IBUS_REQ,
  input  logic              IBUS_BUSY,
  input  logic              IBUS_ACT
);

  state_e            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [1:0]        a_q;
  logic              we_q, sign_q;
  sz_e               sz_q;
  logic              accept, capture, err_n, active_n;

  logic [1:0]        lane_a;
  sz_e               lane_sz;
  logic              lane_sign;
  logic [BA_W-1:0]   lane_ba;
  logic [DATA_W-1:0] lane_wd, lane_rd;

  logic              unused_ce_f;
  assign unused_ce_f = CE_F;

  // In IDLE the lane logic sees the incoming request so strobes/data register on accept.
  assign lane_a    = (state_q == IDLE) ? REQ_A[1:0]     : a_q;
  assign lane_sz   = (state_q == IDLE) ? sz_e'(REQ_SZ)  : sz_q;
  assign lane_sign = (state_q == IDLE) ? REQ_SIGN       : sign_q;

  sh7034_ibus_lane u_lane (
    .a      (lane_a),
    .sz     (lane_sz),
    .sign   (lane_sign),
    .wd     (REQ_WD),
    .di     (IBUS_DI),
    .ba_c   (lane_ba),
    .wdat_c (lane_wd),
    .rdat_c (lane_rd)
  );

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    err_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (CE_R && REQ_VALID) begin
          accept = 1'b1;
          cnt_n  = '0;
          if (misaligned(REQ_A[1:0], sz_e'(REQ_SZ))) begin
            state_n = DONE;
            err_n   = 1'b1;
          end else begin
            state_n = ADDR;
          end
        end
      end
      ADDR: begin
        if (CE_R) begin
          if (!IBUS_ACT) begin
            cnt_n = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
              state_n = DONE;
              err_n   = 1'b1;
            end
          end else if (IBUS_BUSY) begin
            cnt_n = '0;
          end else begin
            state_n = we_q ? DONE : DATA;
          end
        end
      end
      DATA: begin
        if (CE_R) begin
          capture = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign active_n = (state_n == ADDR) || (state_n == DATA);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      we_q     <= 1'b0;
      sign_q   <= 1'b0;
      sz_q     <= SZ_BYTE;
      REQ_ACK  <= 1'b0;
      REQ_ERR  <= 1'b0;
      REQ_BUSY <= 1'b0;
      REQ_RD   <= '0;
      IBUS_A   <= '0;
      IBUS_DO  <= '0;
      IBUS_BA  <= '0;
      IBUS_WE  <= 1'b0;
      IBUS_REQ <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      if (accept) begin
        a_q    <= REQ_A[1:0];
        we_q   <= REQ_WE;
        sign_q <= REQ_SIGN;
        sz_q   <= sz_e'(REQ_SZ);
      end
      // Bus address/data only move when a transaction is actually issued.
      if (accept && (state_n == ADDR)) begin
        IBUS_A  <= REQ_A;
        IBUS_DO <= lane_wd;
      end
      if (capture) REQ_RD <= lane_rd;
      REQ_ACK  <= (state_n == DONE);
      REQ_ERR  <= (state_n == DONE) && err_n;
      REQ_BUSY <= (state_n != IDLE);
      IBUS_REQ <= active_n;
      IBUS_WE  <= (state_n == ADDR) && (accept ? REQ_WE : we_q);
      IBUS_BA  <= active_n ? lane_ba : '0;
    end
  end

endmodule

// File: tb/tb_sh7034_ibus_master.sv
// Scoreboard bench for sh7034_ibus_master: directed accesses, errors, timeout, reset abort.
module tb_sh7034_ibus_master;

  logic        CLK, RST_N, CE_R, CE_F;
  logic        REQ_VALID, REQ_WE, REQ_SIGN;
  logic [27:0] REQ_A;
  logic [1:0]  REQ_SZ;
  logic [31:0] REQ_WD;
  logic        REQ_ACK, REQ_ERR, REQ_BUSY;
  logic [31:0] REQ_RD;
  logic [27:0] IBUS_A;
  logic [31:0] IBUS_DO, IBUS_DI;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE, IBUS_REQ, IBUS_BUSY, IBUS_ACT;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  sh7034_ibus_master dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F),
    .REQ_VALID(REQ_VALID), .REQ_A(REQ_A), .REQ_WE(REQ_WE), .REQ_SZ(REQ_SZ),
    .REQ_SIGN(REQ_SIGN), .REQ_WD(REQ_WD), .REQ_ACK(REQ_ACK), .REQ_RD(REQ_RD),
    .REQ_ERR(REQ_ERR), .REQ_BUSY(REQ_BUSY), .IBUS_A(IBUS_A), .IBUS_DO(IBUS_DO),
    .IBUS_DI(IBUS_DI), .IBUS_BA(IBUS_BA), .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ),
    .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request, push its expectation, then pop and compare when REQ_ACK appears.
  task automatic access(input string tag, input logic [27:0] a, input logic we,
                        input logic [1:0] sz, input logic sign, input logic [31:0] wd,
                        input logic [31:0] di, input logic act, input int busy,
                        input logic exp_req, input logic [3:0] exp_ba, input logic [31:0] exp_do,
                        input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
    exp_t e;
    int   edges;
    int   busy_left;
    bit   got;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_A = a; REQ_WE = we; REQ_SZ = sz; REQ_SIGN = sign; REQ_WD = wd;
    IBUS_DI = di; IBUS_ACT = act; IBUS_BUSY = 1'b0; busy_left = busy;
    e.err = exp_err; e.rd = exp_rd; e.lat = exp_lat;
    sb.push_back(e);
    @(posedge CLK);
    edges = 1;
    #1 REQ_VALID = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        chk({tag, ".ibus_req"}, 32'(IBUS_REQ), 32'(exp_req));
        if (exp_req) begin
          chk({tag, ".ba"}, 32'(IBUS_BA), 32'(exp_ba));
          chk({tag, ".we"}, 32'(IBUS_WE), 32'(we));
          chk({tag, ".addr"}, 32'(IBUS_A), 32'(a));
          if (we) chk({tag, ".do"}, IBUS_DO, exp_do);
        end
      end
      IBUS_BUSY = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (REQ_ACK) got = 1'b1;
      else begin
        @(posedge CLK);
        edges++;
      end
    end
    e = sb.pop_front();
    chk({tag, ".ack_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, ".err"}, 32'(REQ_ERR), 32'(e.err));
      chk({tag, ".rd"}, REQ_RD, e.rd);
      chk({tag, ".lat"}, 32'(edges), 32'(e.lat));
    end
    @(negedge CLK);
    chk({tag, ".ack_pulse"}, 32'(REQ_ACK), 32'd0);
    chk({tag, ".idle"}, 32'({REQ_BUSY, IBUS_REQ, IBUS_BA}), 32'd0);
    IBUS_ACT = 1'b1; IBUS_BUSY = 1'b0;
  endtask

  initial begin
    int acks;
    RST_N = 1'b0; CE_R = 1'b1; CE_F = 1'b0;
    REQ_VALID = 1'b0; REQ_A = '0; REQ_WE = 1'b0; REQ_SZ = '0; REQ_SIGN = 1'b0; REQ_WD = '0;
    IBUS_DI = '0; IBUS_BUSY = 1'b0; IBUS_ACT = 1'b1;
    #12;
    chk("rst.ctl", 32'({REQ_ACK, REQ_ERR, REQ_BUSY, IBUS_REQ, IBUS_WE}), 32'd0);
    chk("rst.ba", 32'(IBUS_BA), 32'd0);
    chk("rst.a", 32'(IBUS_A), 32'd0);
    chk("rst.do", IBUS_DO, 32'd0);
    chk("rst.rd", REQ_RD, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    //     tag      addr           we    sz     sgn   wd            di            act   bsy req ba       do            err   rd            lat
    access("lw",    28'hF000104, 1'b1, 2'd2, 1'b0, 32'h11223344, 32'h0,        1'b1, 0, 1, 4'b1111, 32'h11223344, 1'b0, 32'h0,        2);
    access("rbs",   28'hF000103, 1'b0, 2'd0, 1'b1, 32'h0,        32'h000000F0, 1'b1, 0, 1, 4'b0001, 32'h0,        1'b0, 32'hFFFFFFF0, 3);
    access("rbz",   28'hF000103, 1'b0, 2'd0, 1'b0, 32'h0,        32'h000000F0, 1'b1, 0, 1, 4'b0001, 32'h0,        1'b0, 32'h000000F0, 3);
    access("wwbsy", 28'hF000102, 1'b1, 2'd1, 1'b0, 32'h0000ABCD, 32'h0,        1'b1, 3, 1, 4'b0011, 32'hABCDABCD, 1'b0, 32'h000000F0, 5);
    access("rwmis", 28'hF000101, 1'b0, 2'd1, 1'b0, 32'h0,        32'h12345678, 1'b1, 0, 0, 4'b0000, 32'h0,        1'b1, 32'h000000F0, 1);
    access("rl",    28'hF000108, 1'b0, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b1, 0, 1, 4'b1111, 32'h0,        1'b0, 32'hDEADBEEF, 3);
    access("rws",   28'hF000100, 1'b0, 2'd1, 1'b1, 32'h0,        32'h80017FFF, 1'b1, 0, 1, 4'b1100, 32'h0,        1'b0, 32'hFFFF8001, 3);
    access("rb1",   28'hF000101, 1'b0, 2'd0, 1'b0, 32'h0,        32'h00AB0000, 1'b1, 0, 1, 4'b0100, 32'h0,        1'b0, 32'h000000AB, 3);
    access("wb1",   28'hF000105, 1'b1, 2'd0, 1'b0, 32'h0000005A, 32'h0,        1'b1, 0, 1, 4'b0100, 32'h5A5A5A5A, 1'b0, 32'h000000AB, 2);
    access("wlmis", 28'hF000102, 1'b1, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0,        1'b1, 0, 0, 4'b0000, 32'h0,        1'b1, 32'h000000AB, 1);
    access("rsv",   28'hF000100, 1'b0, 2'd3, 1'b0, 32'h0,        32'h0,        1'b1, 0, 0, 4'b0000, 32'h0,        1'b1, 32'h000000AB, 1);
    access("tmo",   28'hF00010C, 1'b0, 2'd2, 1'b0, 32'h0,        32'h55555555, 1'b0, 0, 1, 4'b1111, 32'h0,        1'b1, 32'h000000AB, 16);

    // Reset pulse while a read is stuck in ADDR: outputs clear at once and no ACK follows.
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_A = 28'hF000200; REQ_WE = 1'b0; REQ_SZ = 2'd2; IBUS_ACT = 1'b0;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    chk("rstmid.pre_req", 32'(IBUS_REQ), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("rstmid.req", 32'({IBUS_REQ, IBUS_WE, REQ_BUSY, REQ_ACK}), 32'd0);
    chk("rstmid.ba", 32'(IBUS_BA), 32'd0);
    chk("rstmid.rd", REQ_RD, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1; IBUS_ACT = 1'b1;
    acks = 0;
    repeat (20) begin
      @(negedge CLK);
      if (REQ_ACK) acks++;
    end
    chk("rstmid.no_ack", 32'(acks), 32'd0);

    access("post",  28'hF000300, 1'b1, 2'd1, 1'b0, 32'h00001234, 32'h0,        1'b1, 0, 1, 4'b1100, 32'h12341234, 1'b0, 32'h0,        2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sh7034_ibus_master.md
# sh7034_ibus_master

Initiator side of the SH7034 internal bus (IBUS): converts single byte/word/long load-store requests from the CPU core into IBUS transactions toward on-chip responders (internal RAM, on-chip peripherals). It generates big-endian byte-lane strobes, replicates write data across lanes, and tracks responder wait states. It also aligns and extends read data and reports address or no-responder errors. It sits between the CPU execution pipeline and the IBUS decode fabric.

## Interface
- TIMEOUT, 15, CE_R edges in ADDR with IBUS_ACT low before bus error (1..15)
- CLK  in  1  system clock
- RST_N  in  1  asynchronous reset, active low
- CE_R  in  1  rising-phase clock enable; all state/register updates occur only on CLK edges with CE_R=1
- CE_F  in  1  falling-phase enable; unused internally, present for bus uniformity
- REQ_VALID  in  1  CPU access request, sampled in IDLE
- REQ_A  in  28  byte address
- REQ_WE  in  1  1=write, 0=read
- REQ_SZ  in  2  0=byte, 1=word, 2=long, 3=reserved (address error)
- REQ_SIGN  in  1  sign-extend read data (byte/word)
- REQ_WD  in  32  write data, right-justified
- REQ_ACK  out  1  one-CLK completion pulse
- REQ_RD  out  32  aligned read data, held until next read completes
- REQ_ERR  out  1  valid with REQ_ACK: 1=address error or timeout
- REQ_BUSY  out  1  state != IDLE
- IBUS_A  out  28  transaction address
- IBUS_DO  out  32  write data to responder
- IBUS_DI  in  32  read data from responder
- IBUS_BA  out  4  byte strobes, BA[3]=bits 31:24 (lowest address)
- IBUS_WE  out  1  write strobe
- IBUS_REQ  out  1  transaction active
- IBUS_BUSY  in  1  responder wait request
- IBUS_ACT  in  1  responder claims address

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE: on CE_R with REQ_VALID, latch A/WE/SZ/SIGN/WD; clear timeout counter. Misalignment (word with A[0]=1, long with A[1:0]!=0, SZ=3) -> DONE with ERR=1; no IBUS_REQ issued. Else -> ADDR.
- ADDR: IBUS_REQ=1, IBUS_WE=latched WE, A/BA/DO driven from latched request. On CE_R:
  - ACT=0: counter+1; at TIMEOUT -> DONE, ERR=1, RD unchanged.
  - ACT=1, BUSY=1: hold ADDR, counter cleared.
  - ACT=1, BUSY=0: write -> DONE; read -> DATA.
- DATA: IBUS_REQ=1, IBUS_WE=0, address held; on CE_R capture lane of IBUS_DI into REQ_RD -> DONE. BUSY ignored here (responders have fixed one-phase read latency).
- DONE: REQ_ACK=1 for exactly one CLK, -> IDLE unconditionally (CE_R not required).
- Lanes: byte BA=1000>>A[1:0], DO={4{WD[7:0]}}; word BA=A[1]?0011:1100, DO={2{WD[15:0]}}; long BA=1111, DO=WD.
- Read: byte lane=DI[31-8*A[1:0] -: 8]; word lane=A[1]?DI[15:0]:DI[31:16]; zero- or sign-extended per SIGN; long unmodified.
- IBUS_REQ, IBUS_WE, IBUS_BA are 0 outside ADDR/DATA; IBUS_A/IBUS_DO hold last value.

## Timing
- Reset: state IDLE; REQ_ACK, REQ_ERR, REQ_BUSY, IBUS_REQ, IBUS_WE=0; IBUS_BA=0; IBUS_A, IBUS_DO, REQ_RD=0; counter=0.
- Zero-wait write: accept edge E0, ADDR spans to E1 (responder writes at E1), ACK high the CLK after E1.
- Zero-wait read: E0 accept, E1 ADDR->DATA, E2 capture, ACK the CLK after E2.
- Each BUSY-high CE_R in ADDR adds one CE_R period.
- Misaligned: ACK+ERR the CLK after E0.
- Timeout: ACK+ERR the CLK after the TIMEOUT-th ACT-low CE_R.
- REQ_VALID outside IDLE ignored; a new request is accepted no earlier than the CE_R following DONE.
- RST_N low mid-transaction: immediate return to reset values; no ACK generated.

## Structure
- Package sh7034_ibus_pkg: size enum (SZ_BYTE/SZ_WORD/SZ_LONG), state enum, BA/replication/extract functions.
- Sub-module sh7034_ibus_lane: combinational BA generation, write replication, read extraction/extension; instantiated once.

## Test plan
- Long write A=0xF000104, WD=0x11223344, ACT=1, BUSY=0 -> BA=1111, DO=0x11223344, ACK after 2 CE_R, ERR=0.
- Byte read A=0xF000103, SIGN=1, DI=0x000000F0 -> BA=0001, REQ_RD=0xFFFFFFF0 after 3 CE_R; SIGN=0 -> 0x000000F0.
- Word write A=0xF000102, WD=0xABCD, BUSY high 3 CE_R -> BA=0011, DO=0xABCDABCD, ACK 3 CE_R later than zero-wait.
- Word read A=0xF000101 -> ACK+ERR next CLK, IBUS_REQ never asserted, REQ_RD unchanged.
- Read with ACT=0 forever -> ACK+ERR after 15 CE_R in ADDR; RST_N pulse mid-ADDR -> IBUS_REQ=0 immediately, no ACK.
